sync_fifo: RTL and testbench



---
 rtl/fifo_ram.sv | 26 ++
 rtl/sync_fifo.sv | 56 +++++
 tb/tb_sync_fifo.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM with synchronous write and a registered read port.
// Storage is not reset. Only the read register clears on rst.
module fifo_ram #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [DEPTH_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   re,
    input  logic [DEPTH_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]       rdata
);
    logic [WIDTH-1:0] mem [2**DEPTH_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of 2**DEPTH_WIDTH words with a registered read port.
// It provides full/empty flags decoded from a registered occupancy count.
module sync_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_WIDTH:0]   count
);
    localparam int DEPTH = 2**DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] CNT_FULL = DEPTH[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] CNT_ONE = 1;
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = 1;

    logic [DEPTH_WIDTH-1:0] wptr, rptr;
    logic wr_acc, rd_acc;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Pointers wrap naturally at DEPTH; the extra count bit distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE;
            if (rd_acc) rptr <= rptr + PTR_ONE;
            if (wr_acc != rd_acc) count <= wr_acc ? count + CNT_ONE : count - CNT_ONE;
        end
    end

    fifo_ram #(
        .WIDTH(WIDTH),
        .DEPTH_WIDTH(DEPTH_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_acc),
        .waddr(wptr),
        .wdata(din),
        .re   (rd_acc),
        .raddr(rptr),
        .rdata(dout)
    );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed stimulus with a reference queue; a monitor checks dout each cycle against the scoreboard.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       full, empty;
    logic [8:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic [7:0] sb_q[$];
    int         m_cnt = 0;
    logic [7:0] m_dout = 8'h00;

    sync_fifo #(.WIDTH(8), .DEPTH_WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .wr_en(wr_en),
        .din  (din),
        .rd_en(rd_en),
        .dout (dout),
        .full (full),
        .empty(empty),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model mirrors what the FIFO must accept.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        logic wa, ra;
        @(negedge clk);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        wa = w && (m_cnt < 256);
        ra = r && (m_cnt > 0);
        if (ra) begin
            m_dout = model_q.pop_front();
            sb_q.push_back(m_dout);
        end
        if (wa) model_q.push_back(d);
        m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int c, input int e, input int f);
        #1;
        chk({tag, "_count"}, int'(count), c);
        chk({tag, "_empty"}, int'(empty), e);
        chk({tag, "_full"}, int'(full), f);
    endtask

    task automatic model_reset();
        model_q.delete();
        sb_q.delete();
        m_cnt  = 0;
        m_dout = 8'h00;
    endtask

    // Monitor: dout must show each accepted read's word one cycle later and hold otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb_q.size() > 0) chk("rd_data", int'(dout), int'(sb_q.pop_front()));
            else chk("dout_hold", int'(dout), int'(m_dout));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_dout", int'(dout), 0);
        #99 rst = 1'b0;

        cyc(1, 8'd1, 0);
        cyc(1, 8'd2, 0);
        cyc(1, 8'd3, 0);
        chk_state("wr3", 3, 0, 0);
        repeat (3) cyc(0, 8'd0, 1);
        chk_state("rd3", 0, 1, 0);

        repeat (2) cyc(0, 8'd0, 1);
        chk_state("rd_empty", 0, 1, 0);
        chk("rd_empty_dout", int'(dout), 3);

        for (int i = 1; i <= 256; i++) cyc(1, 8'(i), 0);
        chk_state("fill", 256, 0, 1);
        cyc(1, 8'hAA, 0);
        chk_state("wr_full", 256, 0, 1);
        repeat (256) cyc(0, 8'd0, 1);
        chk_state("drain", 0, 1, 0);
        chk("drain_last", int'(dout), 0);

        for (int i = 0; i < 10; i++) cyc(1, 8'(100 + i), 0);
        for (int i = 0; i < 20; i++) cyc(1, 8'(150 + i), 1);
        chk_state("rw_mid", 10, 0, 0);
        for (int i = 0; i < 246; i++) cyc(1, 8'(i), 0);
        chk_state("refill", 256, 0, 1);
        cyc(1, 8'h5A, 1);
        chk_state("rw_full", 255, 0, 0);
        chk("rw_full_dout", int'(dout), 160);
        repeat (255) cyc(0, 8'd0, 1);
        chk_state("drain2", 0, 1, 0);
        cyc(1, 8'd77, 1);
        chk_state("rw_empty", 1, 0, 0);
        cyc(0, 8'd0, 1);
        chk_state("rd77", 0, 1, 0);
        chk("rd77_dout", int'(dout), 77);

        for (int i = 0; i < 50; i++) cyc(1, 8'(i + 20), 0);
        cyc(0, 8'd0, 1);
        chk_state("pre_rst", 49, 0, 0);
        chk("pre_rst_dout", int'(dout), 20);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_dout", int'(dout), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        cyc(1, 8'd7, 0);
        cyc(0, 8'd0, 1);
        chk_state("post_rst", 0, 1, 0);
        chk("post_rst_dout", int'(dout), 7);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
